dmem_bridge: RTL and testbench

- Data-memory bus bridge directly downstream of the memory-access stage.
- Takes one load/store request per transaction: byte address, store data, size, signedness.
- Drives a word-addressed memory port with byte enables, using a request/acknowledge handshake.
- Returns aligned, sign/zero-extended load data (or a store completion) with an error flag, and stalls the pipeline while the bus transaction is in flight.

---
 rtl/dmem_bridge_if.sv | 54 +++++
 rtl/dmem_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_dmem_bridge.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_if.sv
// ============================================================================
// dmem_bridge_if : pipeline-side request/response bundle and word-addressed
//                  memory bus bundle for the dmem_bridge data-memory bridge.
// Revision 1.0
// ============================================================================
`default_nettype none

interface dmem_req_if;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   // Master is the memory-access stage, slave is the bridge.
   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, stall, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, stall, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

interface dmem_bus_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   // Master is the bridge, slave is the memory.
   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

`default_nettype wire

// File: rtl/dmem_bridge.sv
// ============================================================================
// dmem_bridge : load/store request to word-addressed req/ack bus bridge with
//               byte enables, lane replication and load extension.
//               Optional macro DMEM_TIMEOUT_EN adds a BUSY-state abort timer.
// Revision 1.0
// ============================================================================
`default_nettype none

module dmem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst,
   dmem_req_if.slave  pipe,
   dmem_bus_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  lane_q, lane_d;
   logic [29:0] waddr_q, waddr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        w_legal;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic        w_busy;
   logic        w_idle;
   logic        w_timeout;

   // ------------------------------------------------------------------------
   // Request decode: alignment, byte enables and store-lane replication
   // ------------------------------------------------------------------------
   always_comb begin
      w_legal = 1'b0;
      w_be    = 4'b0000;
      w_wdata = pipe.req_wdata;
      case (pipe.req_size)
         SZ_BYTE: begin
            w_legal = 1'b1;
            w_be    = 4'b0001 << pipe.req_addr[1:0];
            w_wdata = {4{pipe.req_wdata[7:0]}};
         end
         SZ_HALF: begin
            w_legal = ~pipe.req_addr[0];
            w_be    = 4'b0011 << pipe.req_addr[1:0];
            w_wdata = {2{pipe.req_wdata[15:0]}};
         end
         SZ_WORD: begin
            w_legal = (pipe.req_addr[1:0] == 2'b00);
            w_be    = 4'b1111;
            w_wdata = pipe.req_wdata;
         end
         default: begin
            w_legal = 1'b0;
            w_be    = 4'b0000;
            w_wdata = pipe.req_wdata;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Load extraction from the returned bus word
   // ------------------------------------------------------------------------
   always_comb begin
      w_byte = bus.mem_rdata[{lane_q, 3'b000} +: 8];
      // Legal halfword lanes are 0 and 2, so only lane bit 1 selects.
      w_half = bus.mem_rdata[{lane_q[1], 4'b0000} +: 16];
      w_load = bus.mem_rdata;
      case (size_q)
         SZ_BYTE: w_load = uns_q ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         SZ_HALF: w_load = uns_q ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load = bus.mem_rdata;
      endcase
   end

   // ------------------------------------------------------------------------
   // Optional BUSY abort timer
   // ------------------------------------------------------------------------
`ifdef DMEM_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_cnt_inc = cnt_q + CNT_W'(1);
   // Fires in the BUSY cycle whose increment would reach the limit, so the
   // bus request is held for exactly TIMEOUT_CYCLES cycles.
   assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if ((state_q == BUSY) && !bus.mem_ack) begin
         cnt_d = w_cnt_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign w_timeout          = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Transaction FSM: next state and datapath capture
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      lane_d  = lane_q;
      waddr_d = waddr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (pipe.req_valid) begin
               rdata_d = 32'd0;
               if (w_legal) begin
                  we_d    = pipe.req_we;
                  size_d  = pipe.req_size;
                  uns_d   = pipe.req_unsigned;
                  lane_d  = pipe.req_addr[1:0];
                  waddr_d = pipe.req_addr[31:2];
                  be_d    = w_be;
                  wdata_d = w_wdata;
                  err_d   = 1'b0;
                  state_d = BUSY;
               end else begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         BUSY: begin
            // An acknowledge coinciding with the timeout completes normally.
            if (bus.mem_ack) begin
               rdata_d = we_q ? 32'd0 : w_load;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (w_timeout) begin
               rdata_d = 32'd0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         lane_q  <= 2'b00;
         waddr_q <= 30'd0;
         be_q    <= 4'b0000;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         lane_q  <= lane_d;
         waddr_q <= waddr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign w_idle = (state_q == IDLE);
   assign w_busy = (state_q == BUSY);

   assign pipe.req_ready = w_idle;
   assign pipe.stall     = w_busy | (w_idle & pipe.req_valid);
   assign pipe.rsp_valid = (state_q == RESP);
   assign pipe.rsp_rdata = rdata_q;
   assign pipe.rsp_err   = err_q;

   // Bus signals are quiet outside BUSY so a dropped request leaves no residue.
   assign bus.mem_req   = w_busy;
   assign bus.mem_we    = w_busy & we_q;
   assign bus.mem_addr  = w_busy ? {waddr_q, 2'b00} : 32'd0;
   assign bus.mem_be    = w_busy ? be_q : 4'b0000;
   assign bus.mem_wdata = w_busy ? wdata_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bridge.sv
// ============================================================================
// tb_dmem_bridge : directed self-checking bench for dmem_bridge.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dmem_bridge;

   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;

   dmem_req_if pipe ();
   dmem_bus_if bus ();

   dmem_bridge #(
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .pipe (pipe),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One request from IDLE; mem_ack given after k wait cycles when the access
   // reaches the bus. Fields change while BUSY to show they are ignored.
   task automatic txn(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] bus_rdata, input int k, input logic exp_bus,
                      input logic [3:0] exp_be, input logic [31:0] exp_addr,
                      input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                      input logic exp_err);
      check({tag, ".ready"}, {31'd0, pipe.req_ready}, 32'd1);
      pipe.req_we       = we;
      pipe.req_size     = size;
      pipe.req_unsigned = uns;
      pipe.req_addr     = addr;
      pipe.req_wdata    = wdata;
      pipe.req_valid    = 1'b1;
      #1;
      check({tag, ".stall_idle"}, {31'd0, pipe.stall}, 32'd1);
      step();
      pipe.req_addr  = addr ^ 32'h0000_0F04;
      pipe.req_wdata = ~wdata;
      pipe.req_we    = ~we;
      if (exp_bus) begin
         for (int i = 0; i <= k; i++) begin
            check({tag, ".req"},  {31'd0, bus.mem_req},  32'd1);
            check({tag, ".we"},   {31'd0, bus.mem_we},   {31'd0, we});
            check({tag, ".addr"}, bus.mem_addr,          exp_addr);
            check({tag, ".be"},   {28'd0, bus.mem_be},   {28'd0, exp_be});
            check({tag, ".stall"},{31'd0, pipe.stall},   32'd1);
            check({tag, ".nrsp"}, {31'd0, pipe.rsp_valid}, 32'd0);
            if (we) check({tag, ".wdata"}, bus.mem_wdata, exp_wdata);
            if (i == k) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = bus_rdata;
            end
            step();
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h5A5A_A5A5;
         end
      end
      check({tag, ".req_off"},  {31'd0, bus.mem_req},    32'd0);
      check({tag, ".rsp"},      {31'd0, pipe.rsp_valid}, 32'd1);
      check({tag, ".rdata"},    pipe.rsp_rdata,          exp_rdata);
      check({tag, ".err"},      {31'd0, pipe.rsp_err},   {31'd0, exp_err});
      check({tag, ".stall_rsp"},{31'd0, pipe.stall},     32'd0);
      check({tag, ".nready"},   {31'd0, pipe.req_ready}, 32'd0);
      pipe.req_valid = 1'b0;
      step();
      check({tag, ".rsp_end"},  {31'd0, pipe.rsp_valid}, 32'd0);
      check({tag, ".rdata_clr"}, pipe.rsp_rdata,         32'd0);
      check({tag, ".err_clr"},  {31'd0, pipe.rsp_err},   32'd0);
   endtask

   initial begin
      n_total           = 0;
      n_bad             = 0;
      rst               = 1'b0;
      pipe.req_valid    = 1'b0;
      pipe.req_we       = 1'b0;
      pipe.req_size     = 2'b00;
      pipe.req_unsigned = 1'b0;
      pipe.req_addr     = 32'd0;
      pipe.req_wdata    = 32'd0;
      bus.mem_ack       = 1'b0;
      bus.mem_rdata     = 32'd0;
      step();
      step();
      check("rst.ready", {31'd0, pipe.req_ready}, 32'd1);
      check("rst.stall", {31'd0, pipe.stall},     32'd0);
      check("rst.rsp",   {31'd0, pipe.rsp_valid}, 32'd0);
      check("rst.rdata", pipe.rsp_rdata,          32'd0);
      check("rst.err",   {31'd0, pipe.rsp_err},   32'd0);
      check("rst.req",   {31'd0, bus.mem_req},    32'd0);
      check("rst.be",    {28'd0, bus.mem_be},     32'd0);
      rst = 1'b1;
      step();

      txn("wld",  1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b1,
          4'b1111, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0);
      txn("sbld", 1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 32'h80FF_FFFF, 1, 1'b1,
          4'b1000, 32'h0000_0200, 32'h0, 32'hFFFF_FF80, 1'b0);
      txn("ubld", 1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 32'h80FF_FFFF, 0, 1'b1,
          4'b1000, 32'h0000_0200, 32'h0, 32'h0000_0080, 1'b0);
      txn("hst",  1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'h0000_ABCD, 32'hFFFF_FFFF, 3, 1'b1,
          4'b1100, 32'h0000_0040, 32'hABCD_ABCD, 32'h0, 1'b0);
      txn("misw", 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 32'h0, 0, 1'b0,
          4'b0000, 32'h0, 32'h0, 32'h0, 1'b1);
      txn("bst",  1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h1234_5677, 32'h0, 0, 1'b1,
          4'b0010, 32'h0000_0010, 32'h7777_7777, 32'h0, 1'b0);
      txn("shld", 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 32'h8001_1234, 2, 1'b1,
          4'b1100, 32'h0000_0000, 32'h0, 32'hFFFF_8001, 1'b0);
      txn("uhld", 1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 32'h8001_F234, 0, 1'b1,
          4'b0011, 32'h0000_0000, 32'h0, 32'h0000_F234, 1'b0);
      txn("rsvd", 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 0, 1'b0,
          4'b0000, 32'h0, 32'h0, 32'h0, 1'b1);
      txn("mish", 1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_1111, 32'h0, 0, 1'b0,
          4'b0000, 32'h0, 32'h0, 32'h0, 1'b1);
      txn("wst",  1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 1, 1'b1,
          4'b1111, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 1'b0);

      // Reset while BUSY abandons the transaction; a late ack is ignored.
      pipe.req_we    = 1'b0;
      pipe.req_size  = 2'b10;
      pipe.req_addr  = 32'h0000_0300;
      pipe.req_valid = 1'b1;
      step();
      pipe.req_valid = 1'b0;
      check("rbusy.req", {31'd0, bus.mem_req}, 32'd1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("rbusy.req_off", {31'd0, bus.mem_req},    32'd0);
      check("rbusy.ready",   {31'd0, pipe.req_ready}, 32'd1);
      check("rbusy.rsp",     {31'd0, pipe.rsp_valid}, 32'd0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1111_2222;
      step();
      bus.mem_ack = 1'b0;
      check("rbusy.ack_rsp", {31'd0, pipe.rsp_valid}, 32'd0);
      check("rbusy.ack_req", {31'd0, bus.mem_req},    32'd0);
      check("rbusy.ack_rdy", {31'd0, pipe.req_ready}, 32'd1);
      step();

`ifdef DMEM_TIMEOUT_EN
      begin
         int req_cycles;
         int guard;
         req_cycles     = 0;
         guard          = 0;
         pipe.req_we    = 1'b0;
         pipe.req_size  = 2'b10;
         pipe.req_addr  = 32'h0000_0400;
         pipe.req_valid = 1'b1;
         step();
         pipe.req_valid = 1'b0;
         while (bus.mem_req && guard < 50) begin
            req_cycles++;
            guard++;
            step();
         end
         check("tmo.cycles", req_cycles,                  32'd4);
         check("tmo.rsp",    {31'd0, pipe.rsp_valid},     32'd1);
         check("tmo.err",    {31'd0, pipe.rsp_err},       32'd1);
         check("tmo.rdata",  pipe.rsp_rdata,              32'd0);
         step();
      end
`else
      txn("long", 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 32'h0123_4567, 20, 1'b1,
          4'b1111, 32'h0000_0500, 32'h0, 32'h0123_4567, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
